// File: rtl/bram_wb_ctrl_pkg.sv
// bram_wb_ctrl_pkg: shared FSM encoding and defaults for the BRAM Wishbone slave
package bram_wb_ctrl_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_t;
   localparam int DEF_DELAYS = 10;
   localparam int DEF_ADDR_WIDTH = 10;
   localparam logic [31:0] BRAM_BASE = 32'h3800_0000;
endpackage

// File: rtl/bram_array.sv
// bram_array: single-port 32-bit block RAM with byte-lane writes and registered read
module bram_array #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  re,
   input  logic [3:0]            we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);
   logic [31:0] mem [2**ADDR_WIDTH];
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      if (re) rdata <= mem[addr];
   end
endmodule

// File: rtl/bram_wb_ctrl.sv
// bram_wb_ctrl: Wishbone classic slave fronting block RAM with fixed DELAYS-clock latency
module bram_wb_ctrl
   import bram_wb_ctrl_pkg::*;
#(
   parameter int DELAYS = DEF_DELAYS,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o
);
   state_t                state;
   logic [7:0]            cnt;
   logic                  lat_we;
   logic [3:0]            lat_sel;
   logic [31:0]           lat_dat;
   logic [ADDR_WIDTH-1:0] lat_idx;
   logic [31:0]           rdata;
   logic                  req, fire, rd_en;
   logic [3:0]            wr_en;
   logic                  unused_adr;
   assign req = wbs_cyc_i & wbs_stb_i;
   // array access is suppressed by reset or abort on the same edge
   assign fire = wb_rst_i && req && state == WAIT && cnt == 8'd0;
   assign rd_en = wb_rst_i && req && state == WAIT && cnt == 8'd1 && !lat_we;
   assign wr_en = (fire && lat_we) ? lat_sel : 4'b0000;
   assign unused_adr = ^{wbs_adr_i[31:ADDR_WIDTH+2], wbs_adr_i[1:0]};
   bram_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
      .clk   (wb_clk_i),
      .re    (rd_en),
      .we    (wr_en),
      .addr  (lat_idx),
      .wdata (lat_dat),
      .rdata (rdata)
   );
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         state     <= IDLE;
         cnt       <= '0;
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
      end else begin
         case (state)
            IDLE: if (req) begin
               state   <= WAIT;
               cnt     <= 8'(DELAYS - 1);
               lat_we  <= wbs_we_i;
               lat_sel <= wbs_sel_i;
               lat_dat <= wbs_dat_i;
               lat_idx <= wbs_adr_i[ADDR_WIDTH+1:2];
            end
            WAIT: if (!req) state <= IDLE;
            else if (cnt == 8'd0) begin
               state     <= ACK;
               wbs_ack_o <= 1'b1;
               if (!lat_we) wbs_dat_o <= rdata;
            end else cnt <= cnt - 8'd1;
            ACK: begin
               state     <= IDLE;
               wbs_ack_o <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bram_wb_ctrl.sv
// tb_bram_wb_ctrl: directed self-checking bench for bram_wb_ctrl (DELAYS=10, ADDR_WIDTH=10)
module tb_bram_wb_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] dat = '0, adr = '0;
   logic        ack;
   logic [31:0] dato;
   logic [31:0] rd;
   int          checks = 0, failures = 0;
   bram_wb_ctrl #(.DELAYS(10), .ADDR_WIDTH(10)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_stb_i (stb),
      .wbs_cyc_i (cyc),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_dat_i (dat),
      .wbs_adr_i (adr),
      .wbs_ack_o (ack),
      .wbs_dat_o (dato)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic w, input logic [3:0] s, input logic [31:0] d, input logic [31:0] a);
      cyc = 1'b1; stb = 1'b1; we = w; sel = s; dat = d; adr = a;
   endtask
   // call with the request already driven; the next rising edge is the acceptance edge
   task automatic wait_ack(input string tag, output logic [31:0] r);
      int lat = -1;
      r = 'x;
      @(posedge clk);
      for (int k = 1; k <= 40 && lat < 0; k++) begin
         @(negedge clk);
         if (ack) begin lat = k; r = dato; end
      end
      cyc = 1'b0; stb = 1'b0;
      chk({tag, "_lat"}, 32'(lat), 32'd11);
      @(negedge clk);
      chk({tag, "_width"}, {31'b0, ack}, 32'd0);
   endtask
   task automatic xfer(input string tag, input logic w, input logic [3:0] s, input logic [31:0] d,
                       input logic [31:0] a, output logic [31:0] r);
      @(negedge clk);
      drive(w, s, d, a);
      wait_ack(tag, r);
   endtask
   initial begin
      drive(1'b1, 4'hF, 32'hDEAD_BEEF, 32'h3800_0010);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_ack", {31'b0, ack}, 32'd0);
         chk("rst_dat", dato, 32'h0);
         chk("rst_state", 32'(dut.state), 32'd0);
      end
      rst = 1'b1;
      wait_ack("wr_first", rd);
      chk("wr_keeps_dat", dato, 32'h0);
      xfer("rd10", 1'b0, 4'hF, 32'h0, 32'h3800_0010, rd);
      chk("rd10_data", rd, 32'hDEAD_BEEF);
      xfer("rd13", 1'b0, 4'hF, 32'h0, 32'h3800_0013, rd);
      chk("rd13_data", rd, 32'hDEAD_BEEF);
      xfer("wr20a", 1'b1, 4'hF, 32'h1122_3344, 32'h3800_0020, rd);
      xfer("wr20b", 1'b1, 4'b0101, 32'hAABB_CCDD, 32'h3800_0020, rd);
      chk("wr_hold_dat", dato, 32'hDEAD_BEEF);
      xfer("rd20", 1'b0, 4'hF, 32'h0, 32'h3800_0020, rd);
      chk("lane_data", rd, 32'h11BB_33DD);
      xfer("wr_sel0", 1'b1, 4'h0, 32'hFFFF_FFFF, 32'h3800_0020, rd);
      xfer("rd20b", 1'b0, 4'hF, 32'h0, 32'h3800_0020, rd);
      chk("sel0_data", rd, 32'h11BB_33DD);
      xfer("wr00", 1'b1, 4'hF, 32'h5A5A_5A5A, 32'h3800_0000, rd);
      xfer("rd_alias", 1'b0, 4'hF, 32'h0, 32'h3800_1000, rd);
      chk("alias_data", rd, 32'h5A5A_5A5A);
      xfer("wr30", 1'b1, 4'hF, 32'hCAFE_F00D, 32'h3800_0030, rd);
      @(negedge clk);
      drive(1'b1, 4'hF, 32'h1234_5678, 32'h3800_0030);
      @(posedge clk);
      repeat (4) @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      chk("abort_state", 32'(dut.state), 32'd0);
      for (int k = 0; k < 15; k++) begin
         chk("abort_no_ack", {31'b0, ack}, 32'd0);
         @(negedge clk);
      end
      chk("abort_dat", dato, 32'h5A5A_5A5A);
      xfer("rd30", 1'b0, 4'hF, 32'h0, 32'h3800_0030, rd);
      chk("abort_mem", rd, 32'hCAFE_F00D);
      xfer("wr40", 1'b1, 4'hF, 32'h0101_0101, 32'h3800_0040, rd);
      @(negedge clk);
      drive(1'b1, 4'hF, 32'h0BAD_BEEF, 32'h3800_0040);
      @(posedge clk);
      repeat (6) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_ack", {31'b0, ack}, 32'd0);
      chk("mid_rst_dat", dato, 32'h0);
      rst = 1'b1; cyc = 1'b0; stb = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk("mid_rst_no_ack", {31'b0, ack}, 32'd0);
      end
      xfer("rd40", 1'b0, 4'hF, 32'h0, 32'h3800_0040, rd);
      chk("mid_rst_mem", rd, 32'h0101_0101);
      @(negedge clk);
      drive(1'b0, 4'hF, 32'h0, 32'h3800_0010);
      @(posedge clk);
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         chk($sformatf("b2b_ack_%0d", k), {31'b0, ack}, (k == 11 || k == 23) ? 32'd1 : 32'd0);
         if (k == 11 || k == 23) chk("b2b_dat", dato, 32'hDEAD_BEEF);
      end
      cyc = 1'b0; stb = 1'b0;
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bram_wb_ctrl.md
# bram_wb_ctrl

Wishbone slave that fronts the user-area block RAM, sitting directly downstream of the user-project Wishbone address decoder on its BRAM port (0x3800_0000 window). Accepts single classic-cycle reads and writes, emulates a fixed memory latency of DELAYS clocks, performs byte-lane writes and registered reads, and returns exactly one ack per accepted transfer. Memory contents persist across reset.

## Interface
- DELAYS, 10: clocks from acceptance edge to ack-asserting edge; legal range 2..255
- ADDR_WIDTH, 10: word-address bits (depth 2^ADDR_WIDTH words of 32 bits)
- wb_clk_i  in  1  clock; all logic on rising edge
- wb_rst_i  in  1  reset, synchronous, active-low
- wbs_stb_i  in  1  strobe
- wbs_cyc_i  in  1  cycle, already qualified by decoder address select
- wbs_we_i  in  1  1 = write, 0 = read
- wbs_sel_i  in  4  byte-lane enables, bit n = dat[8n+7:8n]
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  byte address; word index = adr[ADDR_WIDTH+1:2]
- wbs_ack_o  out  1  one-cycle transfer acknowledge (registered)
- wbs_dat_o  out  32  read data (registered)

## Operation
- Request = wbs_cyc_i & wbs_stb_i.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: on request at edge E0 latch we, sel, dat, word index; cnt <= DELAYS-1; -> WAIT.
  - WAIT: cnt decrements each edge. At the edge where cnt == 1 issue array read (read enable, latched index). At the edge where cnt == 0 (E(DELAYS)): perform write if latched we (only lanes with sel=1), capture array read data into wbs_dat_o if read, assert wbs_ack_o, -> ACK.
  - ACK: wbs_ack_o deasserts and state -> IDLE at next edge; inputs ignored in ACK (master's still-high stb of the acknowledged transfer is never re-accepted).
- Abort: request low at any WAIT edge -> IDLE at that edge, no write, no ack, wbs_dat_o unchanged.
- Write with sel = 4'b0000: acked normally, memory unchanged.
- Writes leave wbs_dat_o unchanged; wbs_dat_o holds last read value until next read ack.
- Address bits above ADDR_WIDTH+1 and adr[1:0] ignored; indices alias modulo depth.
- Read-after-write to same word returns new data (write commits before next acceptance).

## Timing
- Reset (wb_rst_i low at an edge): state IDLE, cnt 0, wbs_ack_o 0, wbs_dat_o 32'h0; array untouched. Reset mid-WAIT drops the transfer: no ack, no write.
- Ack latency: ack high in the cycle following E(DELAYS); master samples it at E(DELAYS+1).
- Ack width: exactly 1 cycle, never back-to-back.
- Earliest next acceptance: E(DELAYS+2); throughput one transfer per DELAYS+2 clocks with stb held continuously.
- Array: synchronous read, 1-cycle latency; write and read never in the same cycle.
- Counter width: 8 bits.

## Structure
- Shared package/header: FSM state encoding (IDLE=2'd0, WAIT=2'd1, ACK=2'd2), default DELAYS, default ADDR_WIDTH, BRAM base 32'h3800_0000.
- One sub-module: bram_array — single-port, 4 byte-lane write enables, synchronous registered read, parameter ADDR_WIDTH, no reset.
- bram_wb_ctrl holds FSM, counter, request latches and output registers.

## Test plan
- Reset: hold wb_rst_i low 3 cycles with stb/cyc high -> wbs_ack_o 0, wbs_dat_o 0, no acceptance; release -> request accepted at first edge after release.
- Write 0xDEADBEEF to 0x3800_0010, sel 4'hF, DELAYS=10 -> ack exactly one cycle, first sampled at E11; read 0x3800_0010 -> wbs_dat_o 0xDEADBEEF with ack.
- Byte lanes: write 0x11223344 sel 4'hF then 0xAABBCCDD sel 4'b0101 to 0x3800_0020 -> read returns 0x11BB33DD.
- Aliasing: write 0x5A5A5A5A to 0x3800_0000, read 0x3800_1000 (ADDR_WIDTH=10) -> 0x5A5A5A5A.
- Abort: start write 0x12345678 to 0x3800_0030, drop cyc at E5 -> no ack, state IDLE at E5; later read of 0x3800_0030 returns prior content.
- Back-to-back: stb/cyc held high for two consecutive reads -> ack pulses at cycles 11 and 23 relative to first acceptance (period DELAYS+2), never two acks for one transfer.
